lc3b_mem_arbiter: RTL

//  N-channel memory arbiter for the LC-3b core. It merges NUM_CH requester ports onto one

---
 rtl/lc3b_types.sv | 16 +
 rtl/rr_priority_picker.sv | 39 +++
 rtl/lc3b_mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem: arbiter state encoding and
// a small index helper used by round-robin logic.
package lc3b_types;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } lc3b_arb_state;

  // Channel index after idx, wrapping from n-1 back to 0.
  function automatic int arb_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr_i wins, wrapping around. Tying ptr_i to zero gives fixed priority with
// the lowest index winning.
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int   cand;
  logic found;

  // Walk the channels starting at the pointer and stop at the first request.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        gnt_o[cand[IDX_W-1:0]]  = 1'b1;
        idx_o                   = cand[IDX_W-1:0];
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// N-channel arbiter merging LC-3b requester ports onto one downstream memory
// port. The winning channel's fields are captured at grant so the memory side
// sees stable values for the whole transaction regardless of what the
// requester does meanwhile.
module lc3b_mem_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RR_EN  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_wmask,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [DATA_W/8-1:0]        mem_wmask,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_resp,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int GNT_W  = $clog2(NUM_CH);
  localparam int MASK_W = DATA_W / 8;

  // Per-channel views of the packed request buses.
  logic [MASK_W-1:0] ch_wmask_arr [NUM_CH];
  logic [ADDR_W-1:0] ch_addr_arr  [NUM_CH];
  logic [DATA_W-1:0] ch_wdata_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_wmask_arr[gi] = ch_wmask[gi*MASK_W +: MASK_W];
      assign ch_addr_arr[gi]  = ch_address[gi*ADDR_W +: ADDR_W];
      assign ch_wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Architectural state.
  lc3b_arb_state       state_q;
  logic [GNT_W-1:0]    grant_q;
  logic [NUM_CH-1:0]   grant_oh_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [GNT_W-1:0]    ptr_q;
  logic [NUM_CH-1:0]   served_q;

  // Next-state helpers.
  logic [NUM_CH-1:0]   req_d;
  logic [GNT_W-1:0]    ptr_d;
  logic                rd_d;
  logic                wr_d;
  logic [GNT_W-1:0]    pick_ptr;
  logic [NUM_CH-1:0]   pick_oh;
  logic [GNT_W-1:0]    pick_idx;
  logic                pick_valid;

  // The channel just served is hidden for one IDLE cycle so it is not
  // re-granted while it is still dropping its request.
  assign req_d = (ch_read | ch_write) & ~served_q;

  // Fixed priority is the same picker with the rotation pointer pinned at 0.
  generate
    if (RR_EN != 0) begin : g_rr
      assign pick_ptr = ptr_q;
    end else begin : g_fixed
      assign pick_ptr = '0;
    end
  endgenerate

  rr_priority_picker #(
    .N     (NUM_CH),
    .IDX_W (GNT_W)
  ) u_picker (
    .req_i   (req_d),
    .ptr_i   (pick_ptr),
    .gnt_o   (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // A channel asserting both read and write is treated as a write only.
  assign wr_d  = ch_write[pick_idx];
  assign rd_d  = ch_read[pick_idx] & ~wr_d;
  assign ptr_d = GNT_W'(arb_wrap_inc(int'(grant_q), NUM_CH));

  // Arbitration FSM: grant and capture in IDLE, hold the memory access in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wmask_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      served_q    <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          served_q <= '0;
          if (pick_valid) begin
            state_q     <= ARB_BUSY;
            grant_q     <= pick_idx;
            grant_oh_q  <= pick_oh;
            mem_read_q  <= rd_d;
            mem_write_q <= wr_d;
            wmask_q     <= ch_wmask_arr[pick_idx];
            addr_q      <= ch_addr_arr[pick_idx];
            wdata_q     <= ch_wdata_arr[pick_idx];
          end
        end
        ARB_BUSY: begin
          if (mem_resp) begin
            state_q     <= ARB_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            served_q    <= grant_oh_q;
            if (RR_EN != 0) begin
              ptr_q <= ptr_d;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Completion goes only to the granted channel, and only while a
  // transaction is outstanding; a stray mem_resp in IDLE is dropped.
  assign ch_resp     = (state_q == ARB_BUSY && mem_resp) ? grant_oh_q : '0;
  assign ch_rdata    = mem_rdata;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wmask   = wmask_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule
